// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with inhibit, request-to-send, ACK check and watchdog
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES = 16,
  parameter int FILTER_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, RELEASE, DONE} state_t;
  localparam int CW = $clog2((INHIBIT_CYCLES > RTS_CYCLES ? INHIBIT_CYCLES : RTS_CYCLES) + 1);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, nxt;
  logic [1:0] clk_sy, data_sy;
  logic clk_s, data_s, filt, fall, active, wd_exp, err;
  logic [FW-1:0] fcnt;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wd;
  logic [10:0] sh;
  logic [3:0] bitn;
  assign clk_s = clk_sy[1];
  assign data_s = data_sy[1];
  assign fall = filt & ~clk_s & (fcnt == FW'(FILTER_CYCLES - 1));
  assign active = (state == SEND) || (state == ACK) || (state == RELEASE);
  assign wd_exp = active && (wd == WW'(TIMEOUT_CYCLES - 1));
  assign tx_ready = state == IDLE;
  assign busy = state != IDLE;
  assign ps2_clk_oe = (state == INHIBIT) || (state == RTS);
  assign ps2_data_oe = (state == RTS) || ((state == SEND) && !sh[0]);
  assign tx_done = state == DONE;
  assign tx_error = (state == DONE) && err;
  // two-flop synchronizers; lines idle high
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sy <= 2'b11;
      data_sy <= 2'b11;
    end else begin
      clk_sy <= {clk_sy[0], ps2_clk_in};
      data_sy <= {data_sy[0], ps2_data_in};
    end
  end
  // clock deglitch: accept a new level only after it has persisted FILTER_CYCLES samples
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (clk_s == filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILTER_CYCLES - 1)) begin
      filt <= clk_s;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next-state logic; watchdog expiry preempts every wait on the device
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = tx_valid ? INHIBIT : IDLE;
      INHIBIT: nxt = (cnt == CW'(INHIBIT_CYCLES - 1)) ? RTS : INHIBIT;
      RTS:     nxt = (cnt == CW'(RTS_CYCLES - 1)) ? SEND : RTS;
      SEND:    nxt = wd_exp ? DONE : (fall && bitn == 4'd9) ? ACK : SEND;
      ACK:     nxt = wd_exp ? DONE : fall ? RELEASE : ACK;
      RELEASE: nxt = (wd_exp || (filt && data_s)) ? DONE : RELEASE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // phase counter, watchdog, frame shifter and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      wd <= '0;
      sh <= '0;
      bitn <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (state == nxt && (state == INHIBIT || state == RTS)) ? cnt + 1'b1 : '0;
      wd <= (active && !fall) ? wd + 1'b1 : '0;
      if (state == IDLE && tx_valid) begin
        sh <= {1'b1, ~^tx_data, tx_data, 1'b0};
        bitn <= '0;
        err <= 1'b0;
      end
      if (state == SEND && fall) begin
        sh <= {1'b1, sh[10:1]};
        bitn <= bitn + 1'b1;
      end
      if (state == ACK && fall) err <= data_s;
      if (wd_exp) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed device-model bench for ps2_host_tx
module tb_ps2_host_tx;
  localparam int TO = 2000;
  logic clk = 1'b0, rst = 1'b1, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic ps2_clk_in, ps2_data_in;
  int checks = 0, failures = 0, done_cnt = 0, inh_n, rts_n, d0;
  logic [10:0] frame;
  logic got_done, got_err;
  typedef struct { logic [7:0] d; logic [10:0] f; } vec_t;
  vec_t vecs[3] = '{'{8'hED, 11'h7DA}, '{8'hF4, 11'h5E8}, '{8'h00, 11'h600}};
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;
  always #5 clk = ~clk;
  always @(negedge clk) done_cnt <= done_cnt + int'(tx_done);
  ps2_host_tx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    check("ready_before_send", 32'(tx_ready), 1);
    tx_valid = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask
  task automatic wait_send(output logic ok);
    logic seen = 1'b0;
    ok = 1'b0;
    inh_n = 0;
    rts_n = 0;
    for (int i = 0; i < 20000; i++) begin
      if (seen && !ps2_clk_oe) begin
        ok = 1'b1;
        break;
      end
      seen |= ps2_clk_oe;
      inh_n += int'(ps2_clk_oe & ~ps2_data_oe);
      rts_n += int'(ps2_clk_oe & ps2_data_oe);
      @(negedge clk);
    end
    if (!ok) check("rts_wait_timeout", 0, 1);
  endtask
  task automatic dev_run(input logic ack, input int glitch_at, input int poke_at, input int abort_at);
    logic ok;
    frame = '1;
    got_done = 1'b0;
    got_err = 1'b0;
    wait_send(ok);
    if (!ok) return;
    for (int k = 0; k < 11; k++) begin
      repeat (20) @(negedge clk);
      if (k == glitch_at) begin
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (20) @(negedge clk);
      end
      frame[k] = ps2_data_in;
      dev_clk = 1'b0;
      if (k == 10 && ack) dev_data = 1'b0;
      if (k == poke_at) begin
        tx_valid = 1'b1;
        tx_data = 8'h55;
      end
      repeat (20) @(negedge clk);
      tx_valid = 1'b0;
      if (k + 1 == abort_at) return;
      dev_clk = 1'b1;
      dev_data = 1'b1;
    end
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_done) begin
        got_done = 1'b1;
        got_err = tx_error;
        break;
      end
    end
  endtask
  initial begin
    logic ok;
    int n;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_done", {30'd0, tx_done, tx_error}, 0);
    rst = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_edge_busy", 32'(busy), 0);
    check("idle_edge_done", 32'(done_cnt - d0), 0);
    foreach (vecs[i]) begin
      send(vecs[i].d);
      dev_run(1'b1, -1, -1, -1);
      check("frame", 32'(frame), 32'(vecs[i].f));
      check("parity", 32'(frame[9]), 32'(vecs[i].f[9]));
      check("inhibit_len", 32'(inh_n), 5000);
      check("rts_len", 32'(rts_n), 16);
      check("done", 32'(got_done), 1);
      check("err", 32'(got_err), 0);
      @(negedge clk);
      check("idle_after", 32'(tx_ready), 1);
    end
    send(8'hED);
    dev_run(1'b0, -1, -1, -1);
    check("noack_frame", 32'(frame), 32'h7DA);
    check("noack_done", 32'(got_done), 1);
    check("noack_err", 32'(got_err), 1);
    @(negedge clk);
    check("noack_idle", 32'(tx_ready), 1);
    send(8'hED);
    wait_send(ok);
    n = 0;
    got_done = 1'b0;
    for (int i = 0; i < 3 * TO && ok; i++) begin
      @(negedge clk);
      n++;
      if (tx_done) begin
        got_done = 1'b1;
        check("to_err", 32'(tx_error), 1);
        check("to_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        break;
      end
    end
    check("to_done", 32'(got_done), 1);
    check("to_len", 32'(n), TO);
    @(negedge clk);
    check("to_idle", 32'(tx_ready), 1);
    send(8'hF4);
    dev_run(1'b1, 4, 2, -1);
    check("glitch_frame", 32'(frame), 32'h5E8);
    check("glitch_done", {30'd0, got_done, got_err}, 2);
    @(negedge clk);
    send(8'hED);
    d0 = done_cnt;
    dev_run(1'b1, -1, -1, 5);
    check("abort_frame_lsb", 32'(frame[4:0]), 32'h1A);
    rst = 1'b1;
    @(negedge clk);
    check("abort_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    check("abort_ready", 32'(tx_ready), 1);
    rst = 1'b0;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 0);
    send(8'hFF);
    dev_run(1'b1, -1, -1, -1);
    check("ff_frame", 32'(frame), 32'h7FE);
    check("ff_done", {30'd0, got_done, got_err}, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
